argmax_stream_classifier: RTL
=============================

# argmax_stream_classifier

Parametrised streaming argmax stage at the tail of the CNN datapath: consumes one signed class score per accepted beat from the final fully-connected layer and emits the winning class index together with the top score, runner-up score and decision margin. It generalises the fixed 10-class comparator to any class count and bit width. It processes one score per cycle with no buffer of the whole vector, adds ready/valid backpressure on both sides, and supports back-to-back frames without bubbles.

## Interface
- INPUT_BITS, 12, signed score width.
- NUM_CLASS, 10, scores per frame; legal range 2..2^CLASS_BITS.
- CLASS_BITS, 4, index width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  score beat valid.
- in_ready  out  1  block can accept a score.
- data_in  in  INPUT_BITS  signed score; the k-th accepted beat of a frame is class k.
- out_ready  in  1  downstream accepts the result.
- valid_out  out  1  result valid, held until taken.
- class_decision  out  CLASS_BITS  index of the maximum score.
- max_value  out  INPUT_BITS  signed maximum score.
- second_value  out  INPUT_BITS  signed runner-up score.
- margin  out  INPUT_BITS+1  unsigned, max_value minus second_value.

## Operation
- Input accept: valid_in && in_ready. Output take: valid_out && out_ready.
- in_ready = !valid_out || out_ready (combinational). The block stalls input only while an untaken result is pending.
- Internal state:
  - idx counter, 0..NUM_CLASS-1.
  - running best, best_idx, second.
  - Output register set: class_decision, max_value, second_value, margin.
- Per accepted beat x at idx = i:
  - i==0: best=x, best_idx=0, second=most-negative value (-2^(INPUT_BITS-1)).
  - else if x > best: second=best, best=x, best_idx=i.
  - else if x > second: second=x.
  - Comparisons are signed.
- Tie rule: lowest index wins class_decision. An equal later score becomes second, giving margin 0.
- On the beat with i==NUM_CLASS-1:
  - The post-update best/best_idx/second are loaded into the output registers.
  - valid_out is set.
  - idx wraps to 0.
- margin is computed at load as sign-extended best minus second, in INPUT_BITS+1 bits. It is never negative; the maximum is 2^INPUT_BITS - 1.
- valid_out clears on take unless a new frame completes in the same cycle. In that case it stays 1 and the registers load the new result.
- Simultaneous take and first beat of the next frame is legal; the accumulators and output registers are independent.
- FSM, derived from idx and valid_out:
  - COLLECT: idx counts beats.
  - HOLD: valid_out=1 && !out_ready. Input is stalled and idx is frozen. This state is reached only if a frame completed.
  - HOLD -> COLLECT on take.
- Non-accepted cycles (valid_in low, or stalled) change no state.
- Reset:
  - Outputs: valid_out=0, class_decision=0, max_value=0, second_value=0, margin=0.
  - Internals: idx=0, best/second/best_idx=0.
  - in_ready reads 1 in the first cycle after reset.
- Reset mid-frame discards the partial frame; the next accepted beat is class 0.

## Timing
- Latency: last score accepted at edge T -> valid_out=1 and result visible after edge T (one register stage).
- Throughput: one score per cycle, sustained. With out_ready tied 1, frame n+1 beat 0 may be accepted on the cycle after frame n's last beat.
- Output fields are stable while valid_out=1 && !out_ready.
- No combinational path from data_in to any output. The only combinational path is out_ready -> in_ready.

## Test plan
- Ascending frame 0,1,...,9, out_ready=1 -> one cycle after the last beat:
  - valid_out=1, class_decision=9, max_value=9, second_value=8, margin=1.
  - valid_out low the next cycle.
- Ties: frame 5,7,7,3,... (remaining 0) -> class_decision=1, max_value=7, second_value=7, margin=0.
- Extremes, INPUT_BITS=12: class 4 = 2047, all others -2048 -> class_decision=4, second_value=-2048, margin=4095. An all--2048 frame -> class 0, margin 0.
- Backpressure: out_ready=0 after frame completes.
  - valid_out and fields held 10 cycles; in_ready=0; valid_in beats ignored.
  - Raise out_ready -> take, then the next frame proceeds correctly.
- Back-to-back: 3 frames streamed with valid_in=1 continuously and out_ready=1 -> 3 results on cycles 10, 20, 30 after the start, each correct, no dropped beats.
- Reset mid-frame: assert rst after 4 beats, then send a full 10-beat frame with the max at class 2 -> class_decision=2. The partial frame has no effect; all outputs are 0 during and after rst.

Source files
------------

// File: rtl/argmax_stream_classifier.sv
// Streaming argmax over NUM_CLASS signed scores per frame: one score per beat in,
// one registered result (index, top, runner-up, margin) per frame out.
//
// state     | meaning
// S_COLLECT | no result pending; idx counts accepted beats
// S_HOLD    | result pending on valid_out; input stalls while out_ready is low
module argmax_stream_classifier #(
   parameter int INPUT_BITS = 12,
   parameter int NUM_CLASS  = 10,
   parameter int CLASS_BITS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_in,
   output logic                         in_ready,
   input  logic signed [INPUT_BITS-1:0] data_in,
   input  logic                         out_ready,
   output logic                         valid_out,
   output logic [CLASS_BITS-1:0]        class_decision,
   output logic signed [INPUT_BITS-1:0] max_value,
   output logic signed [INPUT_BITS-1:0] second_value,
   output logic [INPUT_BITS:0]          margin
);

   typedef enum logic {S_COLLECT, S_HOLD} state_e;

   localparam logic [CLASS_BITS-1:0]        LAST_IDX = CLASS_BITS'(NUM_CLASS - 1);
   localparam logic signed [INPUT_BITS-1:0] MIN_VAL  = {1'b1, {(INPUT_BITS-1){1'b0}}};

   state_e                         state_q;
   logic [CLASS_BITS-1:0]          idx_q;
   logic signed [INPUT_BITS-1:0]   best_q, second_q;
   logic [CLASS_BITS-1:0]          best_idx_q;
   logic signed [INPUT_BITS-1:0]   best_d, second_d;
   logic [CLASS_BITS-1:0]          best_idx_d;
   logic [INPUT_BITS:0]            margin_d;
   logic [CLASS_BITS-1:0]          class_q;
   logic signed [INPUT_BITS-1:0]   max_q, sec_q;
   logic [INPUT_BITS:0]            margin_q;
   logic                           accept, take, last;

   assign valid_out      = (state_q == S_HOLD);
   assign in_ready       = !valid_out || out_ready;
   assign accept         = valid_in && in_ready;
   assign take           = valid_out && out_ready;
   assign last           = (idx_q == LAST_IDX);
   assign class_decision = class_q;
   assign max_value      = max_q;
   assign second_value   = sec_q;
   assign margin         = margin_q;

   // Strict '>' keeps the earliest index on ties; the equal later score drops to second.
   always_comb begin
      best_d     = best_q;
      second_d   = second_q;
      best_idx_d = best_idx_q;
      if (idx_q == '0) begin
         best_d     = data_in;
         second_d   = MIN_VAL;
         best_idx_d = '0;
      end else if (data_in > best_q) begin
         second_d   = best_q;
         best_d     = data_in;
         best_idx_d = idx_q;
      end else if (data_in > second_q) begin
         second_d   = data_in;
      end
      margin_d = {best_d[INPUT_BITS-1], best_d} - {second_d[INPUT_BITS-1], second_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_COLLECT;
         idx_q      <= '0;
         best_q     <= '0;
         second_q   <= '0;
         best_idx_q <= '0;
         class_q    <= '0;
         max_q      <= '0;
         sec_q      <= '0;
         margin_q   <= '0;
      end else begin
         if (accept) begin
            idx_q      <= last ? '0 : idx_q + CLASS_BITS'(1);
            best_q     <= best_d;
            second_q   <= second_d;
            best_idx_q <= best_idx_d;
            if (last) begin
               class_q  <= best_idx_d;
               max_q    <= best_d;
               sec_q    <= second_d;
               margin_q <= margin_d;
            end
         end
         case (state_q)
            S_COLLECT: if (accept && last) state_q <= S_HOLD;
            S_HOLD:    if (take && !(accept && last)) state_q <= S_COLLECT;
            default:   state_q <= S_COLLECT;
         endcase
      end
   end

endmodule
